// File: rtl/fip_arith_unit.sv
// Signed fixed-point ADD/SUB/MUL/DIV unit with valid/ready handshakes and an iterative divider.
// Define FIP_SATURATE_EN to clamp overflowing results; otherwise they wrap.

module fip_arith_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_dz
);

  localparam int unsigned N     = WIDTH + FRAC;
  localparam int unsigned CNT_W = $clog2(N + 1);

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

`ifdef FIP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [N-1:0]     dq_q, dq_d;
  logic             neg_q, neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_dz_q, out_dz_d;

  logic                      accept;
  logic [WIDTH:0]            a_ext, b_ext, sum;
  logic                      sum_ovf;
  logic [WIDTH-1:0]          sum_res;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic                      mul_ovf;
  logic [WIDTH-1:0]          mul_res;
  logic [WIDTH-1:0]          a_mag, b_mag, dz_res;
  logic [WIDTH:0]            rem_sh;
  logic                      q_bit;
  logic [WIDTH-1:0]          rem_next;
  logic                      q_ovf;
  logic [WIDTH-1:0]          q_wrap, q_res;

  assign in_ready = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath for ADD/SUB/MUL and divider operand preparation
  always_comb begin
    a_ext   = {in_a[WIDTH-1], in_a};
    b_ext   = {in_b[WIDTH-1], in_b};
    sum     = (in_op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    sum_res = (sum_ovf && SAT) ? (sum[WIDTH] ? MIN_V : MAX_V) : sum[WIDTH-1:0];

    prod    = $signed({{WIDTH{in_a[WIDTH-1]}}, in_a}) * $signed({{WIDTH{in_b[WIDTH-1]}}, in_b});
    prod_sh = prod >>> FRAC;
    mul_ovf = !((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]));
    mul_res = (mul_ovf && SAT) ? (prod_sh[2*WIDTH-1] ? MIN_V : MAX_V) : prod_sh[WIDTH-1:0];

    a_mag  = in_a[WIDTH-1] ? (WIDTH'(0) - in_a) : in_a;
    b_mag  = in_b[WIDTH-1] ? (WIDTH'(0) - in_b) : in_b;
    dz_res = in_a[WIDTH-1] ? MIN_V : MAX_V;
  end

  // One restoring-division step; the dividend shifts out as quotient bits shift in
  always_comb begin
    rem_sh   = {rem_q, dq_q[N-1]};
    q_bit    = (rem_sh >= {1'b0, dvs_q});
    rem_next = q_bit ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];

    q_ovf  = neg_q ? ((|dq_q[N-1:WIDTH]) || (dq_q[WIDTH-1] && (|dq_q[WIDTH-2:0])))
                   : (|dq_q[N-1:WIDTH-1]);
    q_wrap = neg_q ? (WIDTH'(0) - dq_q[WIDTH-1:0]) : dq_q[WIDTH-1:0];
    q_res  = (q_ovf && SAT) ? (neg_q ? MIN_V : MAX_V) : q_wrap;
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    dq_d        = dq_q;
    neg_d       = neg_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_ovf_d   = out_ovf_q;
    out_dz_d    = out_dz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (in_op)
            OP_ADD, OP_SUB: begin
              out_valid_d = 1'b1;
              out_data_d  = sum_res;
              out_tag_d   = in_tag;
              out_ovf_d   = sum_ovf;
              out_dz_d    = 1'b0;
            end
            OP_MUL: begin
              out_valid_d = 1'b1;
              out_data_d  = mul_res;
              out_tag_d   = in_tag;
              out_ovf_d   = mul_ovf;
              out_dz_d    = 1'b0;
            end
            OP_DIV: begin
              if (in_b == '0) begin
                out_valid_d = 1'b1;
                out_data_d  = dz_res;
                out_tag_d   = in_tag;
                out_ovf_d   = 1'b0;
                out_dz_d    = 1'b1;
              end else begin
                state_d = S_DIV;
                cnt_d   = '0;
                rem_d   = '0;
                dq_d    = {a_mag, FRAC'(0)};
                dvs_d   = b_mag;
                neg_d   = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                tag_d   = in_tag;
              end
            end
            default: ;
          endcase
        end
      end
      S_DIV: begin
        if (cnt_q != CNT_W'(N)) begin
          rem_d = rem_next;
          dq_d  = {dq_q[N-2:0], q_bit};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = q_res;
          out_tag_d   = tag_q;
          out_ovf_d   = q_ovf;
          out_dz_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dq_q        <= '0;
      neg_q       <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      dq_q        <= dq_d;
      neg_q       <= neg_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_ovf_q   <= out_ovf_d;
      out_dz_q    <= out_dz_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_ovf   = out_ovf_q;
  assign out_dz    = out_dz_q;

endmodule

// File: tb/tb_fip_arith_unit.sv
// Directed self-checking bench for fip_arith_unit (WIDTH=32, FRAC=16).
// Expected overflow values follow FIP_SATURATE_EN when it is defined.

module tb_fip_arith_unit;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

`ifdef FIP_SATURATE_EN
  localparam logic [31:0] EXP_ADD_POVF = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_ADD_NOVF = 32'h80000000;
  localparam logic [31:0] EXP_MUL_OVF  = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_DIV_OVF  = 32'h7FFFFFFF;
`else
  localparam logic [31:0] EXP_ADD_POVF = 32'h80000000;
  localparam logic [31:0] EXP_ADD_NOVF = 32'h7FFF0000;
  localparam logic [31:0] EXP_MUL_OVF  = 32'h00000000;
  localparam logic [31:0] EXP_DIV_OVF  = 32'h80000000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_ovf;
  logic        out_dz;

  int unsigned n_pass;
  int unsigned n_chk;

  always #5 clk = ~clk;

  fip_arith_unit #(.WIDTH(32), .FRAC(16), .TAG_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_ovf  (out_ovf),
    .out_dz   (out_dz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Issue a non-zero DIV and wait for its result; reports latency and any in_ready leak
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         output int cyc, output bit rdy_bad);
    drive(OP_DIV, a, b, tag);
    tick();
    in_valid = 1'b0;
    cyc      = 0;
    rdy_bad  = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", out_data); else n_pass++;
    n_chk++; if ({out_tag, out_ovf, out_dz} !== 6'h0)
      $display("FAIL reset_flags: got %h want 00", {out_tag, out_ovf, out_dz}); else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
    tick();
  endtask

  task automatic test_mul();
    drive(OP_MUL, 32'h00018000, 32'h00020000, 4'd3);
    n_chk++; if (in_ready !== 1'b1) $display("FAIL mul_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL mul_valid: got %b want 1", out_valid); else n_pass++;
    n_chk++; if (out_data !== 32'h00030000) $display("FAIL mul_data: got %h want 00030000", out_data); else n_pass++;
    n_chk++; if (out_tag !== 4'd3) $display("FAIL mul_tag: got %0d want 3", out_tag); else n_pass++;
    n_chk++; if (out_ovf !== 1'b0) $display("FAIL mul_ovf: got %b want 0", out_ovf); else n_pass++;
    drive(OP_MUL, 32'hFFFF8000, 32'h00030000, 4'd1);
    tick();
    n_chk++; if (out_data !== 32'hFFFE8000) $display("FAIL mul_neg: got %h want fffe8000", out_data); else n_pass++;
    drive(OP_MUL, 32'hFFFFFFFF, 32'h00000001, 4'd2);
    tick();
    n_chk++; if (out_data !== 32'hFFFFFFFF) $display("FAIL mul_floor: got %h want ffffffff", out_data); else n_pass++;
    drive(OP_MUL, 32'h80000000, 32'h80000000, 4'd4);
    tick();
    n_chk++; if ({out_ovf, out_data} !== {1'b1, EXP_MUL_OVF})
      $display("FAIL mul_ovf_data: got %b/%h want 1/%h", out_ovf, out_data, EXP_MUL_OVF); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_add_sub();
    drive(OP_ADD, 32'h7FFF0000, 32'h00010000, 4'd5);
    tick();
    n_chk++; if ({out_ovf, out_data} !== {1'b1, EXP_ADD_POVF})
      $display("FAIL add_povf: got %b/%h want 1/%h", out_ovf, out_data, EXP_ADD_POVF); else n_pass++;
    drive(OP_SUB, 32'h00010000, 32'h00030000, 4'd6);
    tick();
    n_chk++; if ({out_ovf, out_data} !== {1'b0, 32'hFFFE0000})
      $display("FAIL sub_data: got %b/%h want 0/fffe0000", out_ovf, out_data); else n_pass++;
    drive(OP_ADD, 32'h80000000, 32'hFFFF0000, 4'd7);
    tick();
    n_chk++; if ({out_ovf, out_data} !== {1'b1, EXP_ADD_NOVF})
      $display("FAIL add_novf: got %b/%h want 1/%h", out_ovf, out_data, EXP_ADD_NOVF); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_div();
    int cyc;
    bit rdy_bad;
    run_div(32'h00030000, 32'h00020000, 4'd8, cyc, rdy_bad);
    n_chk++; if (cyc !== 49) $display("FAIL div_latency: got %0d want 49", cyc); else n_pass++;
    n_chk++; if (rdy_bad !== 1'b0) $display("FAIL div_ready_low: got %b want 0", rdy_bad); else n_pass++;
    n_chk++; if ({out_ovf, out_dz, out_data} !== {2'b00, 32'h00018000})
      $display("FAIL div_data: got %b%b/%h want 00/00018000", out_ovf, out_dz, out_data); else n_pass++;
    n_chk++; if (out_tag !== 4'd8) $display("FAIL div_tag: got %0d want 8", out_tag); else n_pass++;
    tick();
    run_div(32'hFFFF0000, 32'h00030000, 4'd9, cyc, rdy_bad);
    n_chk++; if ({out_ovf, out_data} !== {1'b0, 32'hFFFFAAAB})
      $display("FAIL div_neg: got %b/%h want 0/ffffaaab", out_ovf, out_data); else n_pass++;
    tick();
    run_div(32'h80000000, 32'hFFFF0000, 4'd10, cyc, rdy_bad);
    n_chk++; if ({out_ovf, out_dz, out_data} !== {2'b10, EXP_DIV_OVF})
      $display("FAIL div_ovf: got %b%b/%h want 10/%h", out_ovf, out_dz, out_data, EXP_DIV_OVF); else n_pass++;
    tick();
  endtask

  task automatic test_div_zero();
    drive(OP_DIV, 32'h00050000, 32'h0, 4'd11);
    tick();
    n_chk++; if ({out_valid, out_ovf, out_dz, out_data} !== {3'b101, 32'h7FFFFFFF})
      $display("FAIL dz_pos: got %b%b%b/%h want 101/7fffffff", out_valid, out_ovf, out_dz, out_data); else n_pass++;
    drive(OP_DIV, 32'hFFFB0000, 32'h0, 4'd12);
    tick();
    n_chk++; if ({out_valid, out_ovf, out_dz, out_data} !== {3'b101, 32'h80000000})
      $display("FAIL dz_neg: got %b%b%b/%h want 101/80000000", out_valid, out_ovf, out_dz, out_data); else n_pass++;
    n_chk++; if (out_tag !== 4'd12) $display("FAIL dz_tag: got %0d want 12", out_tag); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit rdy_bad = 1'b0;
    bit dat_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADD, 32'(i) << 16, 32'h00010000, 4'(i));
      if (in_ready !== 1'b1) rdy_bad = 1'b1;
      tick();
      if ({out_valid, out_tag, out_data} !== {1'b1, 4'(i), 32'(i + 1) << 16}) begin
        dat_bad = 1'b1;
        $display("FAIL b2b_data%0d: got %h want %h", i, out_data, 32'(i + 1) << 16);
      end
    end
    in_valid = 1'b0;
    n_chk++; if (rdy_bad !== 1'b0) $display("FAIL b2b_ready: got stall want none"); else n_pass++;
    n_chk++; if (dat_bad === 1'b0) n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(OP_ADD, 32'h00010000, 32'h00020000, 4'd5);
    tick();
    drive(OP_SUB, 32'h00050000, 32'h00010000, 4'd6);
    n_chk++; if ({out_valid, out_data} !== {1'b1, 32'h00030000})
      $display("FAIL bp_first: got %b/%h want 1/00030000", out_valid, out_data); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if ({out_valid, out_tag, out_data} !== {1'b1, 4'd5, 32'h00030000})
        $display("FAIL bp_hold%0d: got %b/%0d/%h want 1/5/00030000", i, out_valid, out_tag, out_data); else n_pass++;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_chk++; if ({out_valid, out_tag, out_data} !== {1'b1, 4'd6, 32'h00040000})
      $display("FAIL bp_next: got %b/%0d/%h want 1/6/00040000", out_valid, out_tag, out_data); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_div();
    bit seen = 1'b0;
    drive(OP_DIV, 32'h00030000, 32'h00020000, 4'd13);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_chk++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL rst_div_state: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL rst_div_result: got stray result want none"); else n_pass++;
    drive(OP_ADD, 32'h00000001, 32'h00000002, 4'd1);
    tick();
    in_valid = 1'b0;
    n_chk++; if ({out_valid, out_data} !== {1'b1, 32'h00000003})
      $display("FAIL rst_div_after: got %b/%h want 1/00000003", out_valid, out_data); else n_pass++;
    tick();
  endtask

  initial begin
    n_pass    = 0;
    n_chk     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset();
    test_mul();
    test_add_sub();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
